// File: rtl/data_logger.sv
// data_logger: single-clock FIFO between the acquisition front end and the
// serial output path. Stores DEPTH words of DATA_WIDTH bits and releases
// them in arrival order. The read port is registered (one clock latency),
// and the full/empty flags are registered from the next-state occupancy
// count, so neither flag depends combinationally on the enables.
module data_logger #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic                  read_enable,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  full,
  output logic                  empty
);

  // DEPTH must equal 2**ADDR_WIDTH so that the pointers wrap from
  // DEPTH-1 to 0 by plain binary overflow.
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0]   COUNT_ZERO = (ADDR_WIDTH + 1)'(0);
  localparam logic [ADDR_WIDTH:0]   COUNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);

  // Storage array; deliberately not reset, only the control state is.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wptr_q,      wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q,      rptr_d;
  logic [ADDR_WIDTH:0]   count_q,     count_d;
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
  logic                  full_q,      full_d;
  logic                  empty_q,     empty_d;

  logic we_s;
  logic re_s;
  logic wr_ok_s;
  logic rd_ok_s;

  // Request qualification: enables are forced low while reset is high so an
  // undriven enable during reset cannot disturb state.
  always_comb begin
    we_s    = 1'b0;
    re_s    = 1'b0;
    rd_ok_s = 1'b0;
    wr_ok_s = 1'b0;
    if (reset) begin
      we_s = 1'b0;
      re_s = 1'b0;
    end else begin
      we_s = write_enable;
      re_s = read_enable;
    end
    // A read only needs something stored; a write into a full FIFO is still
    // accepted when a read frees a slot on the same edge.
    rd_ok_s = re_s & ~empty_q;
    wr_ok_s = we_s & (~full_q | rd_ok_s);
  end

  // Pointer advance; power-of-two depth makes the wrap implicit.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_ok_s) begin
      wptr_d = wptr_q + PTR_ONE;
    end else begin
      wptr_d = wptr_q;
    end
    if (rd_ok_s) begin
      rptr_d = rptr_q + PTR_ONE;
    end else begin
      rptr_d = rptr_q;
    end
  end

  // Occupancy update: a simultaneous accepted read and write cancel out.
  always_comb begin
    count_d = count_q;
    case ({wr_ok_s, rd_ok_s})
      2'b10:   count_d = count_q + COUNT_ONE;
      2'b01:   count_d = count_q - COUNT_ONE;
      2'b11:   count_d = count_q;
      default: count_d = count_q;
    endcase
  end

  // Read port and status flags; read_data holds when no read is accepted.
  always_comb begin
    read_data_d = read_data_q;
    if (rd_ok_s) begin
      read_data_d = mem_q[rptr_q];
    end else begin
      read_data_d = read_data_q;
    end
    full_d  = (count_d == COUNT_FULL);
    empty_d = (count_d == COUNT_ZERO);
  end

  // Control state register with asynchronous reset to the empty condition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      read_data_q <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      read_data_q <= read_data_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
    end
  end

  // Storage write; only accepted writes touch the array, so an overflow
  // attempt cannot corrupt stored data.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_q[wptr_q] <= write_data;
    end
  end

  assign read_data = read_data_q;
  assign full      = full_q;
  assign empty     = empty_q;

endmodule

// File: tb/tb_data_logger.sv
// Directed bench for data_logger: reset, fill/overflow, ordered drain,
// wrap-around, simultaneous access at full and empty, and mid-run reset.
module tb_data_logger;

  logic        clk;
  logic        reset;
  logic        write_enable;
  logic        read_enable;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        full;
  logic        empty;

  int vectors;
  int miscompares;

  logic [31:0] a_vals [16];

  data_logger #(.DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .write_data   (write_data),
    .read_data    (read_data),
    .full         (full),
    .empty        (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of requests, then sample 1 ns after the rising edge.
  task automatic step(input logic we, input logic re, input logic [31:0] wd);
    write_enable = we;
    read_enable  = re;
    write_data   = wd;
    @(posedge clk);
    #1;
    write_enable = 1'b0;
    read_enable  = 1'b0;
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    write_data   = 32'h0000_0000;
    a_vals = '{32'h1215_3524, 32'hC089_5E81, 32'h8484_D609, 32'hB1F0_5663,
               32'h0687_9B0D, 32'h46DF_998D, 32'hB2C2_8465, 32'h8932_75F2,
               32'h00F3_E301, 32'h0622_3B06, 32'h3B23_F176, 32'h1E8D_CD3D,
               32'h7631_8C62, 32'h7CFD_E9F9, 32'hE33D_5244, 32'hA3C2_0DCA};

    // Reset then idle
    reset = 1'b1;
    #10;
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full",  {31'd0, full},  32'd0);
    chk("rst_rdata", read_data, 32'h0000_0000);
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 1'b1, 32'h0000_0000);
    chk("underflow_rdata", read_data, 32'h0000_0000);
    chk("underflow_empty", {31'd0, empty}, 32'd1);

    // Fill to full, then one overflow attempt
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, a_vals[i]);
      if (i == 0) chk("fill_first_empty", {31'd0, empty}, 32'd0);
      if (i == 14) chk("fill_15_full", {31'd0, full}, 32'd0);
    end
    chk("fill_full", {31'd0, full}, 32'd1);
    step(1'b1, 1'b0, 32'hDEAD_BEEF);
    chk("overflow_full", {31'd0, full}, 32'd1);
    chk("overflow_rdata", read_data, 32'h0000_0000);

    // Drain in order
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 32'h0000_0000);
      chk($sformatf("drain_%0d", i), read_data, a_vals[i]);
      if (i == 0) chk("drain_first_full", {31'd0, full}, 32'd0);
    end
    chk("drain_empty", {31'd0, empty}, 32'd1);
    step(1'b0, 1'b1, 32'h0000_0000);
    chk("drain_extra_rdata", read_data, a_vals[15]);

    // Wrap-around: 10 in, 10 out, then 20 offered with no reads
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'hB000_0000 + 32'(i));
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 32'h0000_0000);
      chk($sformatf("wrap_b_%0d", i), read_data, 32'hB000_0000 + 32'(i));
    end
    chk("wrap_b_empty", {31'd0, empty}, 32'd1);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 32'hD000_0000 + 32'(i));
    chk("wrap_fill_full", {31'd0, full}, 32'd1);

    // Simultaneous read and write while full
    step(1'b1, 1'b1, 32'hCAFE_F00D);
    chk("sim_full_rdata", read_data, 32'hD000_0000);
    chk("sim_full_full", {31'd0, full}, 32'd1);
    for (int i = 1; i < 16; i++) begin
      step(1'b0, 1'b1, 32'h0000_0000);
      chk($sformatf("wrap_d_%0d", i), read_data, 32'hD000_0000 + 32'(i));
    end
    step(1'b0, 1'b1, 32'h0000_0000);
    chk("wrap_cafe", read_data, 32'hCAFE_F00D);
    chk("wrap_d_empty", {31'd0, empty}, 32'd1);

    // Simultaneous read and write while empty: no fall-through
    step(1'b1, 1'b1, 32'h1234_5678);
    chk("sim_empty_rdata", read_data, 32'hCAFE_F00D);
    chk("sim_empty_empty", {31'd0, empty}, 32'd0);
    step(1'b0, 1'b1, 32'h0000_0000);
    chk("sim_empty_pop", read_data, 32'h1234_5678);
    chk("sim_empty_after", {31'd0, empty}, 32'd1);

    // Reset mid-operation with 5 words queued
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'hE000_0000 + 32'(i));
    step(1'b0, 1'b1, 32'h0000_0000);
    chk("pre_rst_rdata", read_data, 32'hE000_0000);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_empty", {31'd0, empty}, 32'd1);
    chk("midrst_rdata", read_data, 32'h0000_0000);
    #9;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 32'hC000_0000 + 32'(i));
      step(1'b0, 1'b0, 32'h0000_0000);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 32'h0000_0000);
      chk($sformatf("post_rst_c_%0d", i), read_data, 32'hC000_0000 + 32'(i));
    end
    chk("post_rst_empty", {31'd0, empty}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
